// File: rtl/if_stage.sv
// Dual-issue instruction fetch: one PC register fetching an aligned 64-bit line
// and presenting up to two instructions per cycle, with branch redirects.
module if_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] Imem2proc_data,
    input  logic        IR_valid,
    input  logic        access_memory,
    input  logic        rs_full,
    input  logic        non_ins_en_in,
    input  logic        rs_almost_full,
    input  logic        one_ins_en_in,
    input  logic        need_take_branchA,
    input  logic        need_take_branchB,
    input  logic [63:0] branch_target_PCA,
    input  logic [63:0] branch_target_PCB,
    input  logic        mispredict_branchA,
    input  logic        mispredict_branchB,
    input  logic [63:0] ex_NPCA,
    input  logic [63:0] ex_NPCB,
    output logic [63:0] proc2Imem_addr,
    output logic [31:0] if_IRA_out,
    output logic [31:0] if_IRB_out,
    output logic [63:0] if_PCA_out,
    output logic [63:0] if_PCB_out,
    output logic [63:0] if_NPCA_out,
    output logic [63:0] if_NPCB_out,
    output logic        if_valid_instA_out,
    output logic        if_valid_instB_out,
    output logic        branch_predictionA,
    output logic        branch_predictionB
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        fetch_ok;
    logic        valid_a;
    logic        valid_b;

    // Older slot A wins; within a slot a taken-branch fix outranks a not-taken fix.
    always_comb begin
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        if (need_take_branchA) begin
            redirect_pc = branch_target_PCA;
        end else if (mispredict_branchA) begin
            redirect_pc = ex_NPCA;
        end else if (need_take_branchB) begin
            redirect_pc = branch_target_PCB;
        end else if (mispredict_branchB) begin
            redirect_pc = ex_NPCB;
        end else begin
            redirect = 1'b0;
        end
    end

    assign fetch_ok = IR_valid & ~access_memory & ~rs_full & ~non_ins_en_in & ~redirect & ~reset;
    assign valid_a  = fetch_ok;
    assign valid_b  = fetch_ok & ~pc_q[2] & ~rs_almost_full & ~one_ins_en_in;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (valid_b) begin
            pc_d = pc_q + 64'd8;
        end else if (valid_a) begin
            pc_d = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= 64'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign proc2Imem_addr     = {pc_q[63:3], 3'b000};
    // An odd-word PC only has the upper word of the line left to issue.
    assign if_IRA_out         = pc_q[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];
    assign if_IRB_out         = pc_q[2] ? 32'h0 : Imem2proc_data[63:32];
    assign if_PCA_out         = pc_q;
    assign if_PCB_out         = pc_q + 64'd4;
    assign if_NPCA_out        = pc_q + 64'd4;
    assign if_NPCB_out        = pc_q + 64'd8;
    assign if_valid_instA_out = valid_a;
    assign if_valid_instB_out = valid_b;
    assign branch_predictionA = 1'b0;
    assign branch_predictionB = 1'b0;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver pushes model-predicted outputs each cycle,
// a negedge monitor pops and compares against the DUT.
module tb_if_stage;

    typedef struct {
        logic        rst;
        logic        irv;
        logic        acc;
        logic        full;
        logic        non;
        logic        almost;
        logic        one;
        logic        nta;
        logic        ntb;
        logic        mpa;
        logic        mpb;
        logic [63:0] tpa;
        logic [63:0] tpb;
        logic [63:0] enpa;
        logic [63:0] enpb;
        logic [63:0] data;
    } stim_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] ira;
        logic [31:0] irb;
        logic [63:0] pca;
        logic [63:0] pcb;
        logic [63:0] npca;
        logic [63:0] npcb;
        logic        va;
        logic        vb;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] Imem2proc_data;
    logic        IR_valid, access_memory, rs_full, non_ins_en_in, rs_almost_full, one_ins_en_in;
    logic        need_take_branchA, need_take_branchB, mispredict_branchA, mispredict_branchB;
    logic [63:0] branch_target_PCA, branch_target_PCB, ex_NPCA, ex_NPCB;
    logic [63:0] proc2Imem_addr;
    logic [31:0] if_IRA_out, if_IRB_out;
    logic [63:0] if_PCA_out, if_PCB_out, if_NPCA_out, if_NPCB_out;
    logic        if_valid_instA_out, if_valid_instB_out, branch_predictionA, branch_predictionB;

    int   tests = 0;
    int   failed = 0;
    exp_t sb_q[$];
    logic [63:0] model_pc;

    always #5 clock = ~clock;

    if_stage dut (
        .clock              (clock),
        .reset              (reset),
        .Imem2proc_data     (Imem2proc_data),
        .IR_valid           (IR_valid),
        .access_memory      (access_memory),
        .rs_full            (rs_full),
        .non_ins_en_in      (non_ins_en_in),
        .rs_almost_full     (rs_almost_full),
        .one_ins_en_in      (one_ins_en_in),
        .need_take_branchA  (need_take_branchA),
        .need_take_branchB  (need_take_branchB),
        .branch_target_PCA  (branch_target_PCA),
        .branch_target_PCB  (branch_target_PCB),
        .mispredict_branchA (mispredict_branchA),
        .mispredict_branchB (mispredict_branchB),
        .ex_NPCA            (ex_NPCA),
        .ex_NPCB            (ex_NPCB),
        .proc2Imem_addr     (proc2Imem_addr),
        .if_IRA_out         (if_IRA_out),
        .if_IRB_out         (if_IRB_out),
        .if_PCA_out         (if_PCA_out),
        .if_PCB_out         (if_PCB_out),
        .if_NPCA_out        (if_NPCA_out),
        .if_NPCB_out        (if_NPCB_out),
        .if_valid_instA_out (if_valid_instA_out),
        .if_valid_instB_out (if_valid_instB_out),
        .branch_predictionA (branch_predictionA),
        .branch_predictionB (branch_predictionB)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count how many slots the line offers and the consumer takes.
    task automatic model(input stim_t s, output exp_t e);
        int          avail;
        int          cap;
        int          n;
        logic        red;
        logic [63:0] tgt;
        red = s.nta | s.mpa | s.ntb | s.mpb;
        tgt = s.nta ? s.tpa : s.mpa ? s.enpa : s.ntb ? s.tpb : s.enpb;
        avail = (model_pc % 8 == 0) ? 2 : 1;
        if (s.rst || red || !s.irv || s.acc || s.full || s.non) cap = 0;
        else if (s.almost || s.one) cap = 1;
        else cap = 2;
        n = (avail < cap) ? avail : cap;
        e.addr = model_pc - (model_pc % 8);
        e.ira  = (avail == 1) ? s.data[63:32] : s.data[31:0];
        e.irb  = (avail == 1) ? 32'h0 : s.data[63:32];
        e.pca  = model_pc;
        e.pcb  = model_pc + 4;
        e.npca = model_pc + 4;
        e.npcb = model_pc + 8;
        e.va   = (n >= 1);
        e.vb   = (n >= 2);
        if (s.rst) model_pc = 64'h0;
        else if (red) model_pc = tgt;
        else model_pc = model_pc + 64'(4 * n);
    endtask

    // Called just after a rising edge; applies inputs for the coming cycle.
    task automatic drive(input stim_t s);
        exp_t e;
        reset              = s.rst;
        IR_valid           = s.irv;
        access_memory      = s.acc;
        rs_full            = s.full;
        non_ins_en_in      = s.non;
        rs_almost_full     = s.almost;
        one_ins_en_in      = s.one;
        need_take_branchA  = s.nta;
        need_take_branchB  = s.ntb;
        mispredict_branchA = s.mpa;
        mispredict_branchB = s.mpb;
        branch_target_PCA  = s.tpa;
        branch_target_PCB  = s.tpb;
        ex_NPCA            = s.enpa;
        ex_NPCB            = s.enpb;
        Imem2proc_data     = s.data;
        model(s, e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    function automatic stim_t base();
        stim_t s;
        s = '{default: '0};
        s.irv  = 1'b1;
        s.data = {$urandom, $urandom};
        return s;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom, $urandom} & ~64'h3;
        if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8 | ({63'h0, 1'b1} << 2) * 64'($urandom_range(0, 1));
        return t;
    endfunction

    function automatic logic pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("addr", proc2Imem_addr, e.addr);
            check("valid_a", {63'h0, if_valid_instA_out}, {63'h0, e.va});
            check("valid_b", {63'h0, if_valid_instB_out}, {63'h0, e.vb});
            check("pred_a", {63'h0, branch_predictionA}, 64'h0);
            check("pred_b", {63'h0, branch_predictionB}, 64'h0);
            check("pc_a", if_PCA_out, e.pca);
            check("npc_a", if_NPCA_out, e.npca);
            check("pc_b", if_PCB_out, e.pcb);
            check("npc_b", if_NPCB_out, e.npcb);
            check("ir_a", {32'h0, if_IRA_out}, {32'h0, e.ira});
            check("ir_b", {32'h0, if_IRB_out}, {32'h0, e.irb});
        end
    end

    initial begin
        stim_t s;
        s = base();
        s.rst = 1'b1;
        reset = 1'b1;
        drive(s);
        model_pc = 64'h0;
        sb_q.delete();
        drive(s);

        // Aligned dual fetch from reset, then 0x8 -> 0x10
        s = base();
        s.data = 64'h1111_1111_2222_2222;
        drive(s);
        drive(s);
        // Taken redirect to 0 at 0x10
        s = base(); s.nta = 1'b1; s.tpa = 64'h0; s.enpa = 64'h14;
        drive(s);
        s = base(); s.acc = 1'b1;
        drive(s);
        s = base();
        drive(s);
        // Not-taken fix to an odd-word address
        s = base(); s.mpa = 1'b1; s.enpa = 64'h14;
        drive(s);
        s = base();
        drive(s);
        drive(s);
        s = base(); s.nta = 1'b1; s.tpa = 64'h4;
        drive(s);
        s = base();
        drive(s);
        s = base(); s.nta = 1'b1; s.tpa = 64'h0;
        drive(s);
        s = base(); s.one = 1'b1;
        drive(s);
        s = base(); s.nta = 1'b1; s.tpa = 64'h0;
        drive(s);
        s = base(); s.full = 1'b1;
        drive(s);
        s = base(); s.irv = 1'b0;
        drive(s);
        // Redirect and stall together; then reset against a redirect
        s = base(); s.acc = 1'b1; s.full = 1'b1; s.ntb = 1'b1; s.tpb = 64'h40; s.mpb = 1'b1;
        drive(s);
        s = base(); s.rst = 1'b1; s.nta = 1'b1; s.tpa = 64'h80;
        drive(s);
        s = base();
        drive(s);
        // Wrap-around at the top of the address space
        s = base(); s.mpb = 1'b1; s.enpb = 64'hFFFF_FFFF_FFFF_FFF8;
        drive(s);
        s = base();
        drive(s);
        drive(s);

        for (int i = 0; i < 400; i++) begin
            s = base();
            s.irv    = ~pct(15);
            s.acc    = pct(15);
            s.full   = pct(10);
            s.non    = pct(10);
            s.almost = pct(15);
            s.one    = pct(15);
            s.nta    = pct(8);
            s.ntb    = pct(8);
            s.mpa    = pct(8);
            s.mpb    = pct(8);
            s.tpa    = rand_target();
            s.tpb    = rand_target();
            s.enpa   = rand_target();
            s.enpb   = rand_target();
            s.rst    = pct(2);
            drive(s);
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
        #1;
        if (sb_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clock  in  1  single rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 Imem2proc_data  in  64  I-mem line at proc2Imem_addr; [31:0]=word at byte offset 0, [63:32]=word at offset 4.
REQ-004 IR_valid  in  1  Imem2proc_data valid this cycle.
REQ-005 access_memory  in  1  memory port taken by a data access this cycle; fetch stalls.
REQ-006 rs_full, non_ins_en_in  in  1 each  downstream accepts zero instructions.
REQ-007 rs_almost_full, one_ins_en_in  in  1 each  downstream accepts at most one instruction.
REQ-008 need_take_branchA/B  in  1 each  resolved branch in slot A/B is taken but was predicted not-taken.
REQ-009 branch_target_PCA/B  in  64 each  taken target for slot A/B.
REQ-010 mispredict_branchA/B  in  1 each  resolved branch in slot A/B is not-taken but was predicted taken.
REQ-011 ex_NPCA/B  in  64 each  fall-through PC (branch PC+4) for slot A/B.
REQ-012 proc2Imem_addr  out  64  8-byte-aligned fetch address.
REQ-013 if_IRA_out, if_IRB_out  out  32 each  fetched instructions; A is older.
REQ-014 if_PCA_out, if_PCB_out  out  64 each  PCs of A and B.
REQ-015 if_NPCA_out, if_NPCB_out  out  64 each  PC+4 of A and B.
REQ-016 if_valid_instA_out, if_valid_instB_out  out  1 each  slot holds a valid instruction.
REQ-017 branch_predictionA/B  out  1 each  prediction for slot A/B; 1=taken.

Function
REQ-018 One 64-bit PC register; all outputs combinational from PC, inputs, and Imem2proc_data.
REQ-019 proc2Imem_addr = {PC[63:3], 3'b000}.
REQ-020 PC[2]=0: IRA=data[31:0], PCA=PC; IRB=data[63:32], PCB=PC+4.
REQ-021 PC[2]=1: IRA=data[63:32], PCA=PC; B invalid, PCB=PC+4, IRB=32'h0.
REQ-022 NPCA=PCA+4, NPCB=PCB+4, 64-bit modulo arithmetic.
REQ-023 fetch_ok = IR_valid & ~access_memory & ~rs_full & ~non_ins_en_in & no redirect (REQ-027).
REQ-024 valid_A = fetch_ok; valid_B = fetch_ok & ~PC[2] & ~rs_almost_full & ~one_ins_en_in.
REQ-025 Next PC without redirect: +8 if A and B valid; +4 if only A valid; PC held if A invalid.
REQ-026 branch_predictionA/B = 0 (static not-taken).
REQ-027 Redirect priority, highest first:
- need_take_branchA -> branch_target_PCA
- mispredict_branchA -> ex_NPCA
- need_take_branchB -> branch_target_PCB
- mispredict_branchB -> ex_NPCB
REQ-028 Any redirect: both valids forced 0 that cycle; next PC = redirect address, regardless of stalls and access_memory.
REQ-029 Unaligned redirect target (bit 2 set) is legal; the next fetch yields only slot A per REQ-021.
REQ-030 Stall and redirect in the same cycle: redirect wins.

Reset
REQ-031 With reset high at a rising edge, PC <= 0; reset dominates redirect.
REQ-032 While reset is high, both valids = 0 and branch predictions = 0; proc2Imem_addr = 0 after the first reset edge.
REQ-033 First cycle after reset release, valids follow REQ-024 with PC=0.

Verification
REQ-034 Reset, then data 64'h1111_1111_2222_2222, IR_valid=1, no stalls -> IRA=2222_2222, PCA=0, NPCA=4, IRB=1111_1111, PCB=4, NPCB=8, both valid, addr=0; next cycle PC=8, addr=8.
REQ-035 At PC=0x10: need_take_branchA=1, branch_target_PCA=0, ex_NPCA=0x14 -> both valids 0 that cycle; next cycle addr=0, PCA=0.
REQ-036 access_memory=1 for one cycle -> both valids 0, PC and addr held; resumes next cycle.
REQ-037 mispredict_branchA=1, ex_NPCA=0x14 -> valids 0; next cycle addr=0x10, PCA=0x14, IRA=data[63:32], NPCA=0x18, B invalid; following cycle PC=0x18.
REQ-038 need_take_branchA=1, branch_target_PCA=0x4 -> next cycle addr=0, only A valid, IRA=data[63:32], PCA=4; then PC=8.
REQ-039 one_ins_en_in=1 at PC=0 -> only A valid, PC advances to 4; rs_full=1 -> no valids, PC held; IR_valid=0 -> no valids, PC held.
